tlk_irq_sched: RTL and testbench
================================

TLK_IRQ_SCHED -- requirements
Module: tlk_irq_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: message queue depth, power of 2, minimum 2.
REQ-002 Parameter IRQ_GAP, default 4: cycles o_irq is held low between successive messages, minimum 1.
REQ-003 Ports: clk  in  1  single clock; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 i_tx_interrupt / i_rx_interrupt / i_loss_interrupt  in  1 each  single-cycle event pulses.
REQ-006 i_rx_frame_length, i_rx_frame_num  in  16 each  valid with i_rx_interrupt.
REQ-007 i_rx_fifo_status, i_sync_loss, i_link_loss  in  1 each  valid with i_loss_interrupt.
REQ-008 i_reg_ren  in  1;  i_reg_raddr  in  16: CPU read strobe and address.
REQ-009 i_reg_wen  in  1;  i_reg_waddr  in  16: CPU write strobe and address (data ignored).
REQ-010 o_reg_rdata  out  64: registered read data.
REQ-011 o_irq  out  1: level interrupt to CPU.
REQ-012 o_drop  out  3: sticky per-source drop flags {loss, rx, tx}.

Function
REQ-013 Messages: tx = {4'd1, 44'h0, 16'h5aa5}; rx = {4'd2, 28'h0, frame_num, frame_length}; loss = {4'd3, 57'h0, fifo_status, sync_loss, link_loss}.
REQ-014 Each source has a one-entry capture slot; an event loads its slot the cycle after the pulse.
REQ-015 Event while the slot is still pending and not draining this cycle: event dropped, o_drop bit set.
REQ-016 Event in the same cycle its slot drains to the FIFO: slot reloads with the new event, no drop.
REQ-017 At most one slot pushes per cycle, only when the FIFO is not full; round-robin arbitration order tx->rx->loss, pointer advances past the granted source.
REQ-018 FIFO full: slots hold contents; further events on full slots are dropped per REQ-015.
REQ-019 Push and pop in the same cycle leave the occupancy unchanged; a push into an empty FIFO is visible at the head the next cycle.
REQ-020 FSM IDLE: o_irq=0; FIFO non-empty -> PRESENT.
REQ-021 FSM PRESENT: o_irq=1; read of 0x0100 -> pop head, go to GAP.
REQ-022 FSM GAP: o_irq=0 for IRQ_GAP cycles -> PRESENT if FIFO non-empty, else IDLE.
REQ-023 Read latency is 1 cycle; o_reg_rdata holds its value until the next read.
REQ-024 Read 0x0100 in PRESENT returns the head message; in IDLE or GAP it returns 64'h0 and does not pop.
REQ-025 Read 0x0108 returns {o_drop in [63:61], 45'h0, occupancy zero-extended in [15:0]}; any other address returns 64'h0.
REQ-026 A write to 0x0100 clears o_drop; a new drop in the same cycle wins.
REQ-027 Occupancy counter width is clog2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 While rst is high: FSM IDLE, FIFO empty, slots empty, RR pointer = tx, o_irq=0, o_reg_rdata=0, o_drop=0.
REQ-029 Events and CPU accesses in a cycle with rst high are ignored.
REQ-030 rst asserted mid-PRESENT discards all queued messages, and o_irq falls the next cycle.

Structure
REQ-031 Shared package tlk_irq_pkg holds type codes 1/2/3, addresses 0x0100/0x0108, MSG_W=64 and the tx signature 16'h5aa5.
REQ-032 One sub-module, tlk_irq_fifo: synchronous FIFO of MSG_W x FIFO_DEPTH with full/empty/count outputs.

Verification
REQ-033 Single rx pulse (len=0x0366, num=0x0010) -> o_irq rises; read 0x0100 returns 0x2000_0000_0010_0366; o_irq low for 4 cycles, then stays low.
REQ-034 tx, rx and loss pulses in the same cycle -> three messages presented in tx, rx, loss order, each separated by 4 low cycles on o_irq.
REQ-035 Two tx pulses 1 cycle apart while the FIFO is full -> second pulse dropped, o_drop=3'b001; a write to 0x0100 clears it to 0.
REQ-036 9 spaced tx events with no reads (FIFO_DEPTH=8) -> 0x0108 reads occupancy 8 and tx slot pending; after one read, occupancy stays 8 and the slot drains.
REQ-037 rst pulse during PRESENT with 3 messages queued -> o_irq=0, 0x0108 reads 0, no message presented afterwards.
REQ-038 Read 0x0100 during GAP -> returns 0 and occupancy is unchanged.

Source files
------------

// File: rtl/tlk_irq_pkg.sv
// ----------------------------------------------------------------------------
// tlk_irq_pkg
// Shared definitions for the TLK interrupt scheduler: message width, type
// codes, CPU register addresses, source/FSM enumerations and helpers that
// build the 64-bit messages.
// ----------------------------------------------------------------------------
package tlk_irq_pkg;

   localparam int MSG_W = 64;

   typedef logic [MSG_W-1:0] msg_t;

   localparam logic [3:0]  TYPE_TX      = 4'd1;
   localparam logic [3:0]  TYPE_RX      = 4'd2;
   localparam logic [3:0]  TYPE_LOSS    = 4'd3;

   localparam logic [15:0] ADDR_MSG     = 16'h0100;
   localparam logic [15:0] ADDR_STATUS  = 16'h0108;

   localparam logic [15:0] TX_SIGNATURE = 16'h5aa5;

   // Event sources; the value doubles as the bit index into the slot vectors.
   typedef enum logic [1:0] {
      SRC_TX   = 2'd0,
      SRC_RX   = 2'd1,
      SRC_LOSS = 2'd2
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } state_e;

   function automatic msg_t make_tx_msg();
      return {TYPE_TX, 44'h0, TX_SIGNATURE};
   endfunction

   function automatic msg_t make_rx_msg(input logic [15:0] frame_num,
                                        input logic [15:0] frame_length);
      return {TYPE_RX, 28'h0, frame_num, frame_length};
   endfunction

   function automatic msg_t make_loss_msg(input logic fifo_status,
                                          input logic sync_loss,
                                          input logic link_loss);
      return {TYPE_LOSS, 57'h0, fifo_status, sync_loss, link_loss};
   endfunction

endpackage

// File: rtl/tlk_irq_fifo.sv
// ----------------------------------------------------------------------------
// tlk_irq_fifo
// Synchronous first-word-fall-through FIFO of MSG_W x DEPTH messages.
//   clk, rst   : clock, synchronous active-high reset
//   push/wdata : write request and data (ignored when full)
//   pop        : remove head (ignored when empty)
//   head       : current head entry, valid whenever empty is low
//   full/empty : status flags
//   count      : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module tlk_irq_fifo
   import tlk_irq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  msg_t                     wdata,
   input  logic                     pop,
   output msg_t                     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   msg_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full && !rst;
   assign do_pop  = pop  && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; entries are only
   // ever read when count says they were written, and leaving the reset off
   // lets the array map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/tlk_irq_sched.sv
// ----------------------------------------------------------------------------
// tlk_irq_sched
// Collects tx / rx / loss event pulses into one-entry capture slots, moves
// them round-robin into a message FIFO, and presents the head message to the
// CPU through a level interrupt with a fixed low gap between messages.
//   clk, rst                        : clock, synchronous active-high reset
//   i_tx/rx/loss_interrupt          : single-cycle event pulses
//   i_rx_frame_length/_num          : rx payload, valid with i_rx_interrupt
//   i_rx_fifo_status, i_sync_loss,
//   i_link_loss                     : loss payload, valid with i_loss_interrupt
//   i_reg_ren/i_reg_raddr           : CPU read strobe / address
//   i_reg_wen/i_reg_waddr           : CPU write strobe / address
//   o_reg_rdata                     : read data, one cycle after the strobe
//   o_irq                           : level interrupt, high while a message
//                                     is presented
//   o_drop                          : sticky drop flags {loss, rx, tx}
// ----------------------------------------------------------------------------
module tlk_irq_sched
   import tlk_irq_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int IRQ_GAP    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_tx_interrupt,
   input  logic              i_rx_interrupt,
   input  logic              i_loss_interrupt,
   input  logic [15:0]       i_rx_frame_length,
   input  logic [15:0]       i_rx_frame_num,
   input  logic              i_rx_fifo_status,
   input  logic              i_sync_loss,
   input  logic              i_link_loss,
   input  logic              i_reg_ren,
   input  logic [15:0]       i_reg_raddr,
   input  logic              i_reg_wen,
   input  logic [15:0]       i_reg_waddr,
   output logic [MSG_W-1:0]  o_reg_rdata,
   output logic              o_irq,
   output logic [2:0]        o_drop
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int GAP_W = $clog2(IRQ_GAP + 1);

   // ---------------------------------------------------------------- slots
   logic [2:0]  evt;
   msg_t        new_msg  [3];
   msg_t        slot_msg [3];
   logic [2:0]  slot_valid;
   logic [2:0]  grant;
   logic [1:0]  grant_idx;
   logic [2:0]  drop_new;
   logic [2:0]  rr_sum;
   logic [1:0]  cand;
   src_e        rr_ptr;
   src_e        rr_next;

   // FIFO interface
   logic              fifo_push;
   msg_t              fifo_wdata;
   logic              fifo_pop;
   msg_t              fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   // FSM
   state_e            state;
   logic [GAP_W-1:0]  gap_cnt;
   logic              drop_clr;

   assign evt        = {i_loss_interrupt, i_rx_interrupt, i_tx_interrupt};
   assign new_msg[0] = make_tx_msg();
   assign new_msg[1] = make_rx_msg(i_rx_frame_num, i_rx_frame_length);
   assign new_msg[2] = make_loss_msg(i_rx_fifo_status, i_sync_loss, i_link_loss);

   // Round-robin search starting at rr_ptr; the first pending slot wins,
   // and nothing is granted while the FIFO is full.
   // NOTE: every variable written here gets a default before any branch so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = 2'd0;
      rr_sum    = '0;
      cand      = 2'd0;
      rr_next   = rr_ptr;
      for (int k = 0; k < 3; k++) begin
         // NOTE: blocking assignments here because each iteration must see the
         // previous iteration's result within the same evaluation.
         rr_sum = {1'b0, rr_ptr} + 3'(k);
         if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
         cand = rr_sum[1:0];
         if ((grant == '0) && slot_valid[cand] && !fifo_full) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
      if (grant != '0) begin
         case (grant_idx)
            2'd0:    rr_next = SRC_RX;
            2'd1:    rr_next = SRC_LOSS;
            default: rr_next = SRC_TX;
         endcase
      end
   end

   assign fifo_push  = (grant != '0);
   assign fifo_wdata = slot_msg[grant_idx];

   // An event hitting a slot that is pending and not draining this cycle is lost.
   assign drop_new   = evt & slot_valid & ~grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= '0;
         rr_ptr     <= SRC_TX;
      end else begin
         rr_ptr <= rr_next;
         for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
               // Draining slot may be refilled by an event in the same cycle.
               slot_valid[i] <= evt[i];
               if (evt[i]) slot_msg[i] <= new_msg[i];
            end else if (evt[i] && !slot_valid[i]) begin
               slot_valid[i] <= 1'b1;
               slot_msg[i]   <= new_msg[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   tlk_irq_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Only a message-register read while a message is presented consumes it.
   assign fifo_pop = i_reg_ren && (i_reg_raddr == ADDR_MSG) && (state == ST_PRESENT);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         o_irq   <= 1'b0;
         gap_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state <= ST_PRESENT;
                  o_irq <= 1'b1;
               end
            end
            ST_PRESENT: begin
               if (fifo_pop) begin
                  state   <= ST_GAP;
                  o_irq   <= 1'b0;
                  gap_cnt <= GAP_W'(IRQ_GAP - 1);
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  if (!fifo_empty) begin
                     state <= ST_PRESENT;
                     o_irq <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               o_irq <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- CPU regs
   assign drop_clr = i_reg_wen && (i_reg_waddr == ADDR_MSG);

   // A drop in the same cycle as the clear survives it.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_drop <= '0;
      end else begin
         o_drop <= (drop_clr ? 3'b000 : o_drop) | drop_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_reg_rdata <= '0;
      end else if (i_reg_ren) begin
         case (i_reg_raddr)
            ADDR_MSG:    o_reg_rdata <= (state == ST_PRESENT) ? fifo_head : '0;
            ADDR_STATUS: o_reg_rdata <= {o_drop, 45'h0, 16'(fifo_count)};
            default:     o_reg_rdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_tlk_irq_sched.sv
// ----------------------------------------------------------------------------
// tb_tlk_irq_sched
// Directed bench for tlk_irq_sched. Each CPU read pushes its hand-computed
// expected data into a scoreboard queue; an independent monitor compares the
// read data one cycle after every accepted read strobe. Interrupt and drop
// levels are checked inline.
// ----------------------------------------------------------------------------
module tb_tlk_irq_sched;

   localparam logic [63:0] TX_MSG    = 64'h1000_0000_0000_5aa5;
   localparam logic [63:0] RX_MSG_A  = 64'h2000_0000_abcd_1234;
   localparam logic [63:0] LOSS_MSG  = 64'h3000_0000_0000_0005;
   localparam logic [63:0] RX_MSG_B  = 64'h2000_0000_0010_0366;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_tx_interrupt    = 1'b0;
   logic        i_rx_interrupt    = 1'b0;
   logic        i_loss_interrupt  = 1'b0;
   logic [15:0] i_rx_frame_length = '0;
   logic [15:0] i_rx_frame_num    = '0;
   logic        i_rx_fifo_status  = 1'b0;
   logic        i_sync_loss       = 1'b0;
   logic        i_link_loss       = 1'b0;
   logic        i_reg_ren         = 1'b0;
   logic [15:0] i_reg_raddr       = '0;
   logic        i_reg_wen         = 1'b0;
   logic [15:0] i_reg_waddr       = '0;
   logic [63:0] o_reg_rdata;
   logic        o_irq;
   logic [2:0]  o_drop;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q [$];
   string       name_q [$];
   logic        rd_seen = 1'b0;

   tlk_irq_sched #(
      .FIFO_DEPTH (8),
      .IRQ_GAP    (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_tx_interrupt    (i_tx_interrupt),
      .i_rx_interrupt    (i_rx_interrupt),
      .i_loss_interrupt  (i_loss_interrupt),
      .i_rx_frame_length (i_rx_frame_length),
      .i_rx_frame_num    (i_rx_frame_num),
      .i_rx_fifo_status  (i_rx_fifo_status),
      .i_sync_loss       (i_sync_loss),
      .i_link_loss       (i_link_loss),
      .i_reg_ren         (i_reg_ren),
      .i_reg_raddr       (i_reg_raddr),
      .i_reg_wen         (i_reg_wen),
      .i_reg_waddr       (i_reg_waddr),
      .o_reg_rdata       (o_reg_rdata),
      .o_irq             (o_irq),
      .o_drop            (o_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // A read accepted at this edge presents data before the next negedge.
   always @(posedge clk) rd_seen <= i_reg_ren && !rst;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_read: got %h, expected no read response", o_reg_rdata);
         end else begin
            check(name_q.pop_front(), o_reg_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [63:0] exp, input string nm);
      i_reg_ren   = 1'b1;
      i_reg_raddr = addr;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      tick();
      i_reg_ren   = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] addr);
      i_reg_wen   = 1'b1;
      i_reg_waddr = addr;
      tick();
      i_reg_wen   = 1'b0;
   endtask

   // ev = {loss, rx, tx}
   task automatic pulse(input logic [2:0] ev);
      i_tx_interrupt   = ev[0];
      i_rx_interrupt   = ev[1];
      i_loss_interrupt = ev[2];
      tick();
      i_tx_interrupt   = 1'b0;
      i_rx_interrupt   = 1'b0;
      i_loss_interrupt = 1'b0;
   endtask

   task automatic wait_irq(input string nm, input int budget);
      int n = 0;
      while (o_irq !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(nm, {63'h0, o_irq}, 64'h1);
   endtask

   task automatic expect_irq_low(input string nm, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check(nm, {63'h0, o_irq}, 64'h0);
         tick();
      end
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap_len;

      // ---------------- reset state
      apply_reset(3);
      check("rst_irq",   {63'h0, o_irq}, 64'h0);
      check("rst_drop",  {61'h0, o_drop}, 64'h0);
      check("rst_rdata", o_reg_rdata, 64'h0);
      do_read(16'h0108, 64'h0, "rst_status");

      // ---------------- three sources in one cycle: tx, rx, loss order
      i_rx_frame_length = 16'h1234;
      i_rx_frame_num    = 16'habcd;
      i_rx_fifo_status  = 1'b1;
      i_sync_loss       = 1'b0;
      i_link_loss       = 1'b1;
      pulse(3'b111);
      wait_irq("rr_irq_first", 20);
      do_read(16'h0100, TX_MSG, "rr_msg_tx");
      gap_len = 0;
      while (o_irq === 1'b0 && gap_len < 20) begin
         gap_len++;
         tick();
      end
      check("rr_gap_len", 64'(gap_len), 64'd4);
      do_read(16'h0100, RX_MSG_A, "rr_msg_rx");
      // Now in the gap: message read returns zero and does not pop.
      do_read(16'h0100, 64'h0, "gap_read_zero");
      do_read(16'h0108, 64'h1, "gap_occupancy");
      wait_irq("rr_irq_third", 20);
      do_read(16'h0100, LOSS_MSG, "rr_msg_loss");
      expect_irq_low("rr_irq_quiet", 10);
      do_read(16'h0108, 64'h0, "rr_status_empty");

      // ---------------- single rx event
      i_rx_frame_length = 16'h0366;
      i_rx_frame_num    = 16'h0010;
      pulse(3'b010);
      wait_irq("rx_irq_rise", 20);
      do_read(16'h0108, 64'h1, "rx_status_one");
      do_read(16'h0100, RX_MSG_B, "rx_msg");
      expect_irq_low("rx_irq_after", 12);
      check("rdata_hold", o_reg_rdata, RX_MSG_B);
      do_read(16'h0004, 64'h0, "bad_addr");

      // ---------------- fill FIFO with tx, then overflow the tx slot
      for (int i = 0; i < 8; i++) begin
         pulse(3'b001);
         tick();
         tick();
      end
      check("fill_irq", {63'h0, o_irq}, 64'h1);
      pulse(3'b001);                       // ninth: parked in the slot
      tick();
      pulse(3'b001);                       // tenth: slot still pending -> drop
      check("drop_tx", {61'h0, o_drop}, 64'h1);
      do_read(16'h0108, 64'h2000_0000_0000_0008, "full_status");
      do_read(16'h0100, TX_MSG, "full_pop");
      tick();
      tick();
      do_read(16'h0108, 64'h2000_0000_0000_0008, "refill_status");
      do_write(16'h0100);
      check("drop_clear", {61'h0, o_drop}, 64'h0);
      wait_irq("refill_irq", 20);
      do_read(16'h0100, TX_MSG, "refill_pop");
      tick();
      tick();
      tick();
      do_read(16'h0108, 64'h7, "slot_drained");

      // ---------------- reset during PRESENT with three queued
      apply_reset(2);
      pulse(3'b111);
      wait_irq("pre_rst_irq", 20);
      tick();
      tick();
      rst            = 1'b1;
      i_tx_interrupt = 1'b1;               // ignored under reset
      i_reg_ren      = 1'b1;               // ignored under reset
      i_reg_raddr    = 16'h0108;
      tick();
      check("rst_mid_irq",   {63'h0, o_irq}, 64'h0);
      check("rst_mid_rdata", o_reg_rdata, 64'h0);
      rst            = 1'b0;
      i_tx_interrupt = 1'b0;
      i_reg_ren      = 1'b0;
      do_read(16'h0108, 64'h0, "rst_mid_status");
      expect_irq_low("rst_mid_quiet", 20);
      do_read(16'h0100, 64'h0, "rst_mid_msg");

      tick();
      @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
